// File: rtl/mem_arbiter.sv
// Two-requester arbiter for the single external memory bus: the fetch (IF) and
// data (MEM) ports share it round-robin, with registered bus outputs and an ACK timeout.
module mem_arbiter #(
  parameter int TIMEOUT = 15,
  parameter int AW      = 32,
  parameter int DW      = 32
) (
  input  logic          CLK1,
  input  logic          RESET,
  input  logic          i_req,
  input  logic [AW-1:0] i_addr,
  output logic [DW-1:0] i_rdata,
  output logic          i_ack,
  input  logic          d_req,
  input  logic          d_write,
  input  logic [1:0]    d_size,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic [DW-1:0] d_rdata,
  output logic          d_ack,
  output logic          bus_err,
  output logic          MREQ,
  output logic          WRITE,
  output logic [1:0]    SIZE,
  output logic [AW-1:0] AD,
  output logic [DW-1:0] DOUT,
  input  logic [DW-1:0] DIN,
  input  logic          ACK
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] GNT_I = 2'd1;
  localparam logic [1:0] GNT_D = 2'd2;

  localparam int         CW     = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  localparam bit         TO_EN  = (TIMEOUT != 0);
  localparam logic [CW-1:0] TO_VAL = CW'(TIMEOUT);

  logic [1:0]    state;
  logic          last_d;
  logic [CW-1:0] cnt;

  logic          i_cand;
  logic          d_cand;
  logic          grant_i;
  logic          grant_d;
  logic [CW-1:0] cnt_inc;
  logic          timeout_hit;

  // A requester whose ack is still high has not yet seen its completion, so it
  // must not be re-granted on the same request level.
  always_comb begin
    i_cand      = i_req & ~i_ack;
    d_cand      = d_req & ~d_ack;
    grant_d     = d_cand & (~i_cand | ~last_d);
    grant_i     = i_cand & ~grant_d;
    cnt_inc     = cnt + CW'(1);
    timeout_hit = TO_EN && (cnt_inc == TO_VAL);
  end

  always_ff @(posedge CLK1) begin
    if (RESET) begin
      state   <= IDLE;
      last_d  <= 1'b0;
      cnt     <= '0;
      MREQ    <= 1'b0;
      WRITE   <= 1'b0;
      SIZE    <= 2'b00;
      AD      <= '0;
      DOUT    <= '0;
      i_rdata <= '0;
      d_rdata <= '0;
      i_ack   <= 1'b0;
      d_ack   <= 1'b0;
      bus_err <= 1'b0;
    end else begin
      i_ack   <= 1'b0;
      d_ack   <= 1'b0;
      bus_err <= 1'b0;
      case (state)
        IDLE: begin
          if (grant_d) begin
            state  <= GNT_D;
            last_d <= 1'b1;
            cnt    <= '0;
            MREQ   <= 1'b1;
            WRITE  <= d_write;
            SIZE   <= d_size;
            AD     <= d_addr;
            DOUT   <= d_wdata;
          end else if (grant_i) begin
            state  <= GNT_I;
            last_d <= 1'b0;
            cnt    <= '0;
            MREQ   <= 1'b1;
            WRITE  <= 1'b0;
            SIZE   <= 2'b10;
            AD     <= i_addr;
            DOUT   <= '0;
          end
        end
        GNT_I, GNT_D: begin
          // A real ACK in the final counted cycle still completes normally.
          if (ACK) begin
            state <= IDLE;
            MREQ  <= 1'b0;
            if (state == GNT_I) begin
              i_rdata <= DIN;
              i_ack   <= 1'b1;
            end else begin
              d_rdata <= DIN;
              d_ack   <= 1'b1;
            end
          end else if (timeout_hit) begin
            state   <= IDLE;
            MREQ    <= 1'b0;
            bus_err <= 1'b1;
            if (state == GNT_I) begin
              i_rdata <= '0;
              i_ack   <= 1'b1;
            end else begin
              d_rdata <= '0;
              d_ack   <= 1'b1;
            end
          end else begin
            cnt <= cnt_inc;
          end
        end
        default: begin
          state <= IDLE;
          MREQ  <= 1'b0;
        end
      endcase
    end
  end

endmodule
